// File: rtl/wb_commit_unit_pkg.sv
// Shared definitions for the writeback commit stage: write-source select
// encodings, commit FSM state encoding and a small write-enable helper.
package wb_commit_unit_pkg;

    // Write-source select encodings used by the MEM stage and forwarding path
    localparam logic [2:0] WB_ALU  = 3'd0;
    localparam logic [2:0] WB_EXT  = 3'd1;
    localparam logic [2:0] WB_DRAM = 3'd2;
    localparam logic [2:0] WB_PC4  = 3'd3;

    // Commit FSM states, also used by the hazard unit
    typedef enum logic [1:0] {
        WBC_IDLE   = 2'd0,
        WBC_WAIT   = 2'd1,
        WBC_COMMIT = 2'd2
    } wbc_state_e;

    // A register-file write only happens for writing instructions to a non-x0 target
    function automatic logic is_rf_write(input logic we, input logic [4:0] wr);
        return we && (wr != 5'd0);
    endfunction

endpackage

// File: rtl/wb_commit_unit_src_mux.sv
// Combinational 4-way writeback source select; unknown encodings fall back
// to the ALU result so a corrupted select never produces undefined data.
module wb_src_mux
    import wb_commit_unit_pkg::*;
(
    input  logic [2:0]  wsel,
    input  logic [31:0] alu_c,
    input  logic [31:0] sext,
    input  logic [31:0] pc4,
    input  logic [31:0] dram,
    output logic [31:0] wd
);

    // Select the write data from the requested source
    always_comb begin
        wd = alu_c;
        case (wsel)
            WB_ALU:  wd = alu_c;
            WB_EXT:  wd = sext;
            WB_DRAM: wd = dram;
            WB_PC4:  wd = pc4;
            default: wd = alu_c;
        endcase
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit stage: accepts one retiring instruction per cycle, holds
// loads until the DRAM response (or a timeout), and issues a single
// registered register-file write plus the commit trace.
module wb_commit_unit
    import wb_commit_unit_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_pc,
    input  logic        mem_we,
    input  logic [4:0]  mem_wR,
    input  logic [2:0]  mem_wsel,
    input  logic [31:0] mem_alu_c,
    input  logic [31:0] mem_sext,
    input  logic [31:0] mem_pc4,
    input  logic        dram_rsp_valid,
    input  logic [31:0] dram_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_wR,
    output logic [31:0] rf_wD,
    output logic        pend_valid,
    output logic [4:0]  pend_wR,
    output logic        err_timeout,
    output logic        err_spurious,
    output logic        debug_wb_have_inst,
    output logic [31:0] debug_wb_pc,
    output logic        debug_wb_ena,
    output logic [4:0]  debug_wb_reg,
    output logic [31:0] debug_wb_value
);

    localparam int unsigned CW = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(LOAD_TIMEOUT);

    wbc_state_e    state_r;
    wbc_state_e    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [31:0]   ld_pc_r;
    logic [4:0]    ld_wr_r;

    logic          ready_s;
    logic          ld_latch_s;
    logic          commit_s;
    logic          timeout_s;
    logic [31:0]   c_pc_s;
    logic          c_we_s;
    logic [4:0]    c_wr_s;
    logic [31:0]   c_wd_s;
    logic [31:0]   src_wd_s;

    logic          rf_we_r;
    logic [4:0]    rf_wr_r;
    logic [31:0]   rf_wd_r;
    logic          have_inst_r;
    logic [31:0]   dbg_pc_r;
    logic          pend_valid_r;
    logic [4:0]    pend_wr_r;
    logic          err_timeout_r;
    logic          err_spurious_r;

    wb_src_mux u_src_mux (
        .wsel  (mem_wsel),
        .alu_c (mem_alu_c),
        .sext  (mem_sext),
        .pc4   (mem_pc4),
        .dram  (dram_rdata),
        .wd    (src_wd_s)
    );

    // Next-state, accept decision and the commit payload for the next cycle
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ready_s     = 1'b0;
        ld_latch_s  = 1'b0;
        commit_s    = 1'b0;
        timeout_s   = 1'b0;
        c_pc_s      = 32'd0;
        c_we_s      = 1'b0;
        c_wr_s      = 5'd0;
        c_wd_s      = 32'd0;
        case (state_r)
            WBC_IDLE, WBC_COMMIT: begin
                ready_s = 1'b1;
                if (mem_valid) begin
                    if ((mem_wsel == WB_DRAM) && mem_we) begin
                        state_nxt_s = WBC_WAIT;
                        ld_latch_s  = 1'b1;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else begin
                        state_nxt_s = WBC_COMMIT;
                        commit_s    = 1'b1;
                        c_pc_s      = mem_pc;
                        c_we_s      = mem_we;
                        c_wr_s      = mem_wR;
                        c_wd_s      = src_wd_s;
                    end
                end else begin
                    state_nxt_s = WBC_IDLE;
                end
            end
            WBC_WAIT: begin
                cnt_nxt_s = cnt_r + CW'(1'b1);
                if (dram_rsp_valid) begin
                    state_nxt_s = WBC_COMMIT;
                    commit_s    = 1'b1;
                    c_pc_s      = ld_pc_r;
                    c_we_s      = 1'b1;
                    c_wr_s      = ld_wr_r;
                    c_wd_s      = dram_rdata;
                end else if (cnt_nxt_s == TIMEOUT_CNT) begin
                    // Give up on the load: commit zero so the pipeline keeps moving
                    state_nxt_s = WBC_COMMIT;
                    commit_s    = 1'b1;
                    timeout_s   = 1'b1;
                    c_pc_s      = ld_pc_r;
                    c_we_s      = 1'b1;
                    c_wr_s      = ld_wr_r;
                    c_wd_s      = 32'd0;
                end else begin
                    state_nxt_s = WBC_WAIT;
                end
            end
            default: begin
                state_nxt_s = WBC_IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State register and load wait counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= WBC_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Capture the PC and destination of an outstanding load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_pc_r <= 32'd0;
            ld_wr_r <= 5'd0;
        end else if (ld_latch_s) begin
            ld_pc_r <= mem_pc;
            ld_wr_r <= mem_wR;
        end
    end

    // Register-file write port and commit trace, valid only in the commit cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_r     <= 1'b0;
            rf_wr_r     <= 5'd0;
            rf_wd_r     <= 32'd0;
            have_inst_r <= 1'b0;
            dbg_pc_r    <= 32'd0;
        end else begin
            rf_we_r     <= commit_s && is_rf_write(c_we_s, c_wr_s);
            rf_wr_r     <= c_wr_s;
            rf_wd_r     <= c_wd_s;
            have_inst_r <= commit_s;
            dbg_pc_r    <= c_pc_s;
        end
    end

    // Pending-load destination exported to the hazard unit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid_r <= 1'b0;
            pend_wr_r    <= 5'd0;
        end else begin
            pend_valid_r <= (state_nxt_s == WBC_WAIT);
            if (ld_latch_s) begin
                pend_wr_r <= mem_wR;
            end else if (state_nxt_s == WBC_WAIT) begin
                pend_wr_r <= ld_wr_r;
            end else begin
                pend_wr_r <= 5'd0;
            end
        end
    end

    // Sticky error flags: load timeout and response with nothing outstanding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_timeout_r  <= 1'b0;
            err_spurious_r <= 1'b0;
        end else begin
            if (timeout_s) begin
                err_timeout_r <= 1'b1;
            end
            if (dram_rsp_valid && (state_r != WBC_WAIT)) begin
                err_spurious_r <= 1'b1;
            end
        end
    end

    assign mem_ready          = ready_s;
    assign rf_we              = rf_we_r;
    assign rf_wR              = rf_wr_r;
    assign rf_wD              = rf_wd_r;
    assign pend_valid         = pend_valid_r;
    assign pend_wR            = pend_wr_r;
    assign err_timeout        = err_timeout_r;
    assign err_spurious       = err_spurious_r;
    assign debug_wb_have_inst = have_inst_r;
    assign debug_wb_pc        = dbg_pc_r;
    assign debug_wb_ena       = rf_we_r;
    assign debug_wb_reg       = rf_wr_r;
    assign debug_wb_value     = rf_wd_r;

endmodule
